// File: rtl/psum_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the psum memory arbiter.
// The slave modport is the arbiter's view; master is the view of the requesters and the SRAM.
interface psum_mem_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;
  logic              dr_valid;
  logic              dr_ready;
  logic [ADDR_W-1:0] dr_addr;
  logic              dr_rvalid;
  logic [DATA_W-1:0] dr_rdata;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, dr_valid, dr_addr, mem_rdata,
    output wr_ready, rd_ready, rd_rvalid, rd_rdata, dr_ready, dr_rvalid, dr_rdata,
           mem_we, mem_re, mem_addr, mem_wdata, busy
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, dr_valid, dr_addr, mem_rdata,
    input  wr_ready, rd_ready, rd_rvalid, rd_rdata, dr_ready, dr_rvalid, dr_rdata,
           mem_we, mem_re, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/psum_mem_arbiter.sv
// Arbitrates one single-port psum SRAM between buffered MAC write-back, psum reload and host drain.
// Round-robin WB->RD->DR, with forced write-buffer drain when full or when a read hits a buffered address.
module psum_mem_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 2
) (
  input  logic                clk,
  input  logic                arst_n_in,
  psum_mem_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(WB_DEPTH);

  typedef enum logic [1:0] {REQ_WB = 2'd0, REQ_RD = 2'd1, REQ_DR = 2'd2} req_e;

  logic [ADDR_W-1:0]   buf_addr [WB_DEPTH];
  logic [DATA_W-1:0]   buf_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] buf_vld_q;
  logic [PTR_W-1:0]    head_q, tail_q;
  logic                rtag_rd_q, rtag_dr_q;
  req_e                rr_q, rr_d;

  logic       full, empty, push, pop;
  logic       haz_rd, haz_dr, force_wb;
  logic [2:0] elig, gnt;  // bit 0 = WB, bit 1 = RD, bit 2 = DR

  assign full  = &buf_vld_q;
  assign empty = ~|buf_vld_q;
  assign push  = bus.wr_valid && !full;
  assign pop   = gnt[0];

  // Hazard sees only entries present at the start of the cycle; a same-cycle push is not visible.
  always_comb begin
    haz_rd = 1'b0;
    haz_dr = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (buf_vld_q[i] && (buf_addr[i] == bus.rd_addr)) haz_rd = 1'b1;
      if (buf_vld_q[i] && (buf_addr[i] == bus.dr_addr)) haz_dr = 1'b1;
    end
    haz_rd = haz_rd && bus.rd_valid;
    haz_dr = haz_dr && bus.dr_valid;
  end

  assign force_wb = full || haz_rd || haz_dr;
  assign elig     = {bus.dr_valid && !haz_dr, bus.rd_valid && !haz_rd, !empty};

  // Round-robin pointer: state register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!arst_n_in) rr_q <= REQ_WB;
    else            rr_q <= rr_d;
  end

  // Grant selection and next pointer.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    gnt  = 3'b000;
    rr_d = rr_q;
    if (force_wb) begin
      gnt = 3'b001;
    end else begin
      case (rr_q)
        REQ_RD:  if (elig[1]) gnt = 3'b010; else if (elig[2]) gnt = 3'b100; else if (elig[0]) gnt = 3'b001;
        REQ_DR:  if (elig[2]) gnt = 3'b100; else if (elig[0]) gnt = 3'b001; else if (elig[1]) gnt = 3'b010;
        default: if (elig[0]) gnt = 3'b001; else if (elig[1]) gnt = 3'b010; else if (elig[2]) gnt = 3'b100;
      endcase
    end
    if (gnt[0])      rr_d = REQ_RD;
    else if (gnt[1]) rr_d = REQ_DR;
    else if (gnt[2]) rr_d = REQ_WB;
  end

  // Memory drive and read handshakes for the granted requester.
  always_comb begin
    bus.rd_ready  = gnt[1];
    bus.dr_ready  = gnt[2];
    bus.mem_we    = gnt[0];
    bus.mem_re    = gnt[1] || gnt[2];
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt[0]) begin
      bus.mem_addr  = buf_addr[head_q];
      bus.mem_wdata = buf_data[head_q];
    end else if (gnt[1]) begin
      bus.mem_addr  = bus.rd_addr;
    end else if (gnt[2]) begin
      bus.mem_addr  = bus.dr_addr;
    end
  end

  // Write-buffer pointers, occupancy and the in-flight read tag.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      buf_vld_q <= '0;
      rtag_rd_q <= 1'b0;
      rtag_dr_q <= 1'b0;
    end else begin
      if (pop) begin
        buf_vld_q[head_q] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      if (push) begin
        buf_vld_q[tail_q] <= 1'b1;
        tail_q            <= tail_q + 1'b1;
      end
      rtag_rd_q <= gnt[1];
      rtag_dr_q <= gnt[2];
    end
  end

  // NOTE: buffer storage has no reset; the valid bits alone decide what an entry means.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail_q] <= bus.wr_addr;
      buf_data[tail_q] <= bus.wr_data;
    end
  end

  assign bus.wr_ready  = !full;
  assign bus.rd_rvalid = rtag_rd_q;
  assign bus.dr_rvalid = rtag_dr_q;
  assign bus.rd_rdata  = rtag_rd_q ? bus.mem_rdata : '0;
  assign bus.dr_rdata  = rtag_dr_q ? bus.mem_rdata : '0;
  assign bus.busy      = !empty || bus.wr_valid || bus.rd_valid || bus.dr_valid || rtag_rd_q || rtag_dr_q;
endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Scoreboard bench: a queue-based arbitration model predicts each cycle's outputs and read data;
// a negedge monitor compares them against the DUT and also acts as the psum SRAM.
module tb_psum_mem_arbiter;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 32;
  localparam int WB_DEPTH = 2;

  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  always #5 clk = ~clk;

  psum_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  psum_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .bus       (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic              we, re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_ready, rd_ready, dr_ready, rd_rvalid, dr_rvalid, busy;
  } exp_t;

  // Reference model state
  wr_t               m_buf[$];
  int                m_ptr;   // 0 = WB, 1 = RD, 2 = DR
  int                m_last;  // reader granted last cycle: 0 none, 1 RD, 2 DR
  logic [DATA_W-1:0] m_mem [8];
  bit                m_wr_acc, m_rd_gnt, m_dr_gnt;

  // Scoreboard queues
  exp_t              exp_q[$];
  logic [DATA_W-1:0] rd_exp_q[$];
  logic [DATA_W-1:0] dr_exp_q[$];

  // SRAM environment
  logic [DATA_W-1:0] env_mem [8];
  bit                env_rd_pend;
  logic [2:0]        env_raddr;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_buf(input logic [ADDR_W-1:0] a);
    foreach (m_buf[i]) if (m_buf[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus plus the model's prediction for that cycle.
  task automatic cycle(input bit wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input bit rv, input logic [ADDR_W-1:0] ra,
                       input bit dv, input logic [ADDR_W-1:0] da);
    exp_t e;
    bit   elig[3];
    bit   haz_rd, haz_dr, full;
    int   g, idx;
    @(posedge clk); #1;
    arst_n_in     = 1'b1;
    bus.mem_rdata = env_rd_pend ? env_mem[env_raddr] : DATA_W'($urandom);
    bus.wr_valid  = wv; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_valid  = rv; bus.rd_addr = ra;
    bus.dr_valid  = dv; bus.dr_addr = da;

    haz_rd  = rv && in_buf(ra);
    haz_dr  = dv && in_buf(da);
    full    = (m_buf.size() == WB_DEPTH);
    elig[0] = (m_buf.size() != 0);
    elig[1] = rv && !haz_rd;
    elig[2] = dv && !haz_dr;
    g = -1;
    if (full || haz_rd || haz_dr) g = 0;
    else for (int k = 0; k < 3; k++) begin
      idx = (m_ptr + k) % 3;
      if (g < 0 && elig[idx]) g = idx;
    end

    e = '{default: '0};
    e.wr_ready  = !full;
    e.rd_ready  = (g == 1);
    e.dr_ready  = (g == 2);
    e.rd_rvalid = (m_last == 1);
    e.dr_rvalid = (m_last == 2);
    e.busy      = (m_buf.size() != 0) || wv || rv || dv || (m_last != 0);
    if (g == 0) begin
      e.we = 1'b1; e.addr = m_buf[0].addr; e.wdata = m_buf[0].data;
      m_mem[m_buf[0].addr[2:0]] = m_buf[0].data;
      void'(m_buf.pop_front());
    end else if (g == 1) begin
      e.re = 1'b1; e.addr = ra;
      rd_exp_q.push_back(m_mem[ra[2:0]]);
    end else if (g == 2) begin
      e.re = 1'b1; e.addr = da;
      dr_exp_q.push_back(m_mem[da[2:0]]);
    end
    m_last = (g > 0) ? g : 0;
    if (g >= 0) m_ptr = (g + 1) % 3;
    if (wv && !full) m_buf.push_back('{wa, wd});
    exp_q.push_back(e);
    m_wr_acc = wv && !full;
    m_rd_gnt = (g == 1);
    m_dr_gnt = (g == 2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk); #1;
    arst_n_in     = 1'b0;
    bus.wr_valid  = 1'b0; bus.rd_valid = 1'b0; bus.dr_valid = 1'b0;
    bus.mem_rdata = '0;
    m_buf.delete(); rd_exp_q.delete(); dr_exp_q.delete();
    m_ptr = 0; m_last = 0;
    e = '{default: '0};
    e.wr_ready = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor and SRAM model
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_ready",  bus.wr_ready,  e.wr_ready);
        check("rd_ready",  bus.rd_ready,  e.rd_ready);
        check("dr_ready",  bus.dr_ready,  e.dr_ready);
        check("mem_we",    bus.mem_we,    e.we);
        check("mem_re",    bus.mem_re,    e.re);
        check("mem_addr",  bus.mem_addr,  e.addr);
        check("mem_wdata", bus.mem_wdata, e.wdata);
        check("rd_rvalid", bus.rd_rvalid, e.rd_rvalid);
        check("dr_rvalid", bus.dr_rvalid, e.dr_rvalid);
        check("busy",      bus.busy,      e.busy);
        if (bus.rd_rvalid) begin
          if (rd_exp_q.size() == 0) check("rd_rvalid_unexpected", bus.rd_rvalid, 1'b0);
          else                      check("rd_rdata", bus.rd_rdata, rd_exp_q.pop_front());
        end else check("rd_rdata_idle", bus.rd_rdata, '0);
        if (bus.dr_rvalid) begin
          if (dr_exp_q.size() == 0) check("dr_rvalid_unexpected", bus.dr_rvalid, 1'b0);
          else                      check("dr_rdata", bus.dr_rdata, dr_exp_q.pop_front());
        end else check("dr_rdata_idle", bus.dr_rdata, '0);
      end
      if (bus.mem_we) env_mem[bus.mem_addr[2:0]] = bus.mem_wdata;
      env_rd_pend = bus.mem_re;
      env_raddr   = bus.mem_addr[2:0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit                wv, rv, dv;
    logic [ADDR_W-1:0] wa, ra, da;
    logic [DATA_W-1:0] wd, v;
    int                guard;

    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.dr_valid = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0; bus.dr_addr = '0;
    bus.mem_rdata = '0;
    env_rd_pend = 1'b0; env_raddr = '0;
    for (int i = 0; i < 8; i++) begin
      v = DATA_W'($urandom);
      m_mem[i] = v; env_mem[i] = v;
    end

    // Reset and idle, then a single write drained the next cycle
    do_reset();
    idle(1);
    cycle(1'b1, 20'd5, 32'hAB, 1'b0, '0, 1'b0, '0);
    idle(2);

    // RD and DR continuously valid on an empty buffer: alternating grants
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b1, 20'd1, 1'b1, 20'd2);
    idle(2);

    // Read-after-write hazard on address 7
    do_reset();
    cycle(1'b1, 20'd7, 32'h11, 1'b0, '0, 1'b0, '0);
    guard = 0;
    do begin
      cycle(1'b0, '0, '0, 1'b1, 20'd7, 1'b0, '0);
      guard++;
    end while (!m_rd_gnt && guard < 10);
    idle(2);

    // Three back-to-back writes with both readers pending
    do_reset();
    wv = 1'b0; rv = 1'b1; dv = 1'b1;
    for (int n = 0; n < 3; n++) begin
      guard = 0;
      do begin
        cycle(1'b1, ADDR_W'(n), DATA_W'(32'hC0 + n), rv, 20'd4, dv, 20'd5);
        if (m_rd_gnt) rv = 1'b0;
        if (m_dr_gnt) dv = 1'b0;
        guard++;
      end while (!m_wr_acc && guard < 10);
    end
    idle(4);

    // Reset with two buffered writes and a drain read in flight
    do_reset();
    cycle(1'b1, 20'd3, 32'h33, 1'b1, 20'd6, 1'b0, '0);
    cycle(1'b1, 20'd4, 32'h44, 1'b0, '0,    1'b1, 20'd5);
    do_reset();
    idle(3);

    // Randomized traffic on a small address set, holding requests until accepted
    wv = 1'b0; rv = 1'b0; dv = 1'b0;
    wa = '0; ra = '0; da = '0; wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        do_reset();
        wv = 1'b0; rv = 1'b0; dv = 1'b0;
      end
      if (!wv && $urandom_range(0, 2) != 0) begin
        wv = 1'b1; wa = ADDR_W'($urandom_range(0, 7)); wd = DATA_W'($urandom);
      end
      if (!rv && $urandom_range(0, 1) == 1) begin rv = 1'b1; ra = ADDR_W'($urandom_range(0, 7)); end
      if (!dv && $urandom_range(0, 1) == 1) begin dv = 1'b1; da = ADDR_W'($urandom_range(0, 7)); end
      cycle(wv, wa, wd, rv, ra, dv, da);
      if (m_wr_acc) wv = 1'b0;
      if (m_rd_gnt) rv = 1'b0;
      if (m_dr_gnt) dv = 1'b0;
    end
    idle(4);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    check("exp_q_drained",   exp_q.size(),    0);
    check("rd_data_drained", rd_exp_q.size(), 0);
    check("dr_data_drained", dr_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/psum_mem_arbiter.md
Name: psum_mem_arbiter

Overview:
- Shares one single-port partial-sum memory (1 access/cycle, 1-cycle read latency) between three requesters:
  - MAC write-back (WB), buffered in a small write FIFO;
  - partial-sum reload (RD) from the conv controller;
  - host output drain (DR).
- Sits between the controller/MAC datapath and the psum SRAM.
- Replaces direct controller drive of the memory's we/re/addr.
- Round-robin fairness with a full-buffer override and a read-after-write hazard stall.

Parameters:
- ADDR_W, 20, psum memory address width
- DATA_W, 32, psum word width
- WB_DEPTH, 2, write-buffer entries (power of two, >=2)

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- wr_valid  in  1  write-back request
- wr_ready  out  1  write accepted into buffer
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_valid  in  1  reload read request
- rd_ready  out  1  reload read granted this cycle
- rd_addr  in  ADDR_W  reload address
- rd_rvalid  out  1  reload data valid
- rd_rdata  out  DATA_W  reload data
- dr_valid  in  1  drain read request
- dr_ready  out  1  drain read granted this cycle
- dr_addr  in  ADDR_W  drain address
- dr_rvalid  out  1  drain data valid
- dr_rdata  out  DATA_W  drain data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
- busy  out  1  buffer non-empty, any request pending, or read in flight

Behaviour:
- Reset (async, arst_n_in=0):
  - Write buffer emptied, no entries retained.
  - RR pointer = WB; in-flight read tag cleared.
  - Outputs: wr_ready=1, rd_ready=dr_ready=0, mem_we=mem_re=0, rd_rvalid=dr_rvalid=0, busy=0.
- Reset mid-operation: buffered writes are dropped; the rvalid of a read issued in the cycle before reset is suppressed.
- Write path:
  - wr_ready = buffer not full; no same-cycle pop-through when full.
  - Handshake: wr_valid && wr_ready pushes {addr, data} in order.
  - Duplicate addresses are kept as separate entries, written in FIFO order.
- Read handshake:
  - Requester holds valid/addr stable until ready.
  - ready is combinational and equals "granted this cycle".
- Eligibility each cycle:
  - WB eligible if buffer non-empty.
  - RD/DR eligible if valid and addr matches no buffered entry (hazard).
- Grant (exactly one per cycle, or none):
  1. Buffer full, or any valid read blocked by hazard -> WB granted (forced drain).
  2. Otherwise, round-robin among eligible in order WB->RD->DR, starting at the RR pointer.
  3. Pointer update: after any grant, pointer = requester after the grantee. Forced grants also update the pointer.
- Memory drive:
  - WB grant: mem_we=1, mem_addr/wdata = FIFO head; head popped.
  - RD/DR grant: mem_re=1, mem_addr = requester addr; grantee tag registered.
  - No grant: mem_we=mem_re=0, mem_addr=0, mem_wdata=0.
- Read return:
  - Cycle after an RD/DR grant, that requester's rvalid=1 and its rdata = mem_rdata (combinational passthrough).
  - Non-selected rdata = 0.
  - Latency from ready to rvalid: exactly 1 cycle.
  - Back-to-back grants to the same reader give consecutive rvalids.
- Same cycle: a push and a pop of the write buffer update occupancy by net 0; a push into the buffer does not affect hazard checks until the next cycle.
- Starvation bound: any continuously valid requester is granted within WB_DEPTH+3 cycles.

Test Plan:
- Reset, idle → wr_ready=1, all strobes 0, busy=0. Then one write (addr 5, data 0xAB) → mem_we=1 with addr 5 / wdata 0xAB exactly one cycle later.
- RD and DR both continuously valid (addrs 1, 2), buffer empty, pointer=WB → grants alternate RD, DR, RD…; each rvalid arrives 1 cycle after its ready with the matching mem_rdata.
- Three back-to-back writes with RD/DR valid and WB_DEPTH=2 → wr_ready=0 on the third beat. Forced WB grant that cycle, third write accepted the next cycle, no write lost.
- Write addr 7 data 0x11 buffered while rd_addr=7 valid → rd_ready held 0 until the entry is written. Subsequent read returns 0x11.
- Assert arst_n_in for 1 cycle with 2 buffered writes and a read in flight → no mem_we for those entries, no rvalid, wr_ready=1 after reset.
- All three continuously valid for 30 cycles → each requester granted 10 times, gap ≤ WB_DEPTH+3 cycles.
